// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM encoding, widths and counter-width helper for debounce_sync
package debounce_pkg;

   typedef enum logic {ST_STABLE, ST_QUALIFY} state_e;

   localparam int GLITCH_CNT_W = 8;

   function automatic int cnt_width(int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/debounce_sync_if.sv
// debounce_sync_if: raw level in, debounced level out; DEBOUNCE_GLITCH_CNT_EN adds glitch_cnt
interface debounce_sync_if;
   import debounce_pkg::*;
   logic in;
   logic out;
   logic qualifying;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [GLITCH_CNT_W-1:0] glitch_cnt;
`endif
   modport master (
      output in,
      input  out,
      input  qualifying
`ifdef DEBOUNCE_GLITCH_CNT_EN
      , input glitch_cnt
`endif
   );
   modport slave (
      input  in,
      output out,
      output qualifying
`ifdef DEBOUNCE_GLITCH_CNT_EN
      , output glitch_cnt
`endif
   );
endinterface

// File: rtl/debounce_sync_sync_2ff.sv
// sync_2ff: reusable 1-bit two-flop metastability synchroniser with configurable reset value
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic s1_q, s2_q;
   // two back-to-back flops give the first one a full cycle to resolve
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= RST_VAL;
         s2_q <= RST_VAL;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
      end
   end
   assign q = s2_q;
endmodule

// File: rtl/debounce_sync.sv
// debounce_sync: synchronise a raw level and pass it on only after STABLE_CYCLES steady clocks; DEBOUNCE_GLITCH_CNT_EN adds a saturating rejected-bounce counter
module debounce_sync
   import debounce_pkg::*;
#(
   parameter int   STABLE_CYCLES = 16,
   parameter logic RST_VAL       = 1'b0
) (
   input logic           clk,
   input logic           rst,
   debounce_sync_if.slave bus
);
   localparam int CNT_W = cnt_width(STABLE_CYCLES);

   logic             s2;
   state_e           st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_q, out_d;
   logic             qual_q, qual_d;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic                    reject;
   logic [GLITCH_CNT_W-1:0] glitch_q, glitch_d;
`endif

   sync_2ff #(.RST_VAL(RST_VAL)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.in),
      .q   (s2)
   );

   // qualifier: time a candidate change, restart on any bounce back to out
   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      out_d = out_q;
`ifdef DEBOUNCE_GLITCH_CNT_EN
      reject = 1'b0;
`endif
      if (st_q == ST_STABLE) begin
         if (s2 != out_q) begin
            if (STABLE_CYCLES == 1) begin
               out_d = s2;
            end else begin
               st_d  = ST_QUALIFY;
               cnt_d = CNT_W'(1);
            end
         end
      end else if (s2 == out_q) begin
         st_d  = ST_STABLE;
         cnt_d = '0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
         reject = 1'b1;
`endif
      end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
         st_d  = ST_STABLE;
         cnt_d = '0;
         out_d = s2;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      qual_d = (st_d == ST_QUALIFY);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      glitch_d = (reject && glitch_q != '1) ? glitch_q + GLITCH_CNT_W'(1) : glitch_q;
`endif
   end

   // state, counter and registered outputs; reset discards any partial count
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q   <= ST_STABLE;
         cnt_q  <= '0;
         out_q  <= RST_VAL;
         qual_q <= 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
         glitch_q <= '0;
`endif
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         out_q  <= out_d;
         qual_q <= qual_d;
`ifdef DEBOUNCE_GLITCH_CNT_EN
         glitch_q <= glitch_d;
`endif
      end
   end

   assign bus.out        = out_q;
   assign bus.qualifying = qual_q;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   assign bus.glitch_cnt = glitch_q;
`endif
endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: table-driven and hand-sequenced checks of debounce_sync (A: 8 cycles, reset 0; B: 1 cycle, reset 1); DEBOUNCE_GLITCH_CNT_EN enables glitch counter checks
module tb_debounce_sync;
   logic clk = 1'b0;
   logic rst_a, rst_b;
   int   ecnt = 0;
   int   total = 0;
   int   bad = 0;

   typedef struct {
      int    e;
      bit    b;
      logic  o;
      logic  q;
      string nm;
   } exp_t;

   typedef struct {
      logic  in_v;
      int    hold;
      logic  o;
      logic  q;
      string nm;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[13];

   debounce_sync_if ifa ();
   debounce_sync_if ifb ();

   debounce_sync #(.STABLE_CYCLES(8), .RST_VAL(1'b0)) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (ifa.slave)
   );

   debounce_sync #(.STABLE_CYCLES(1), .RST_VAL(1'b1)) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (ifb.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, ecnt);
      end
   endtask

   task automatic push(input int dt, input bit b, input logic o, input logic q, input string nm);
      exp_t x;
      x.e  = ecnt + dt;
      x.b  = b;
      x.o  = o;
      x.q  = q;
      x.nm = nm;
      sb.push_back(x);
   endtask

   task automatic step();
      exp_t x;
      @(posedge clk);
      ecnt++;
      @(negedge clk);
      while (sb.size() != 0 && sb[0].e <= ecnt) begin
         x = sb.pop_front();
         if (x.e != ecnt) chk({x.nm, "_missed"}, 8'(x.e), 8'(ecnt));
         chk({x.nm, "_out"},  x.b ? ifb.out : ifa.out, x.o);
         chk({x.nm, "_qual"}, x.b ? ifb.qualifying : ifa.qualifying, x.q);
      end
      chk("b_never_qual", ifb.qualifying, 1'b0);
   endtask

   initial begin
      tbl = '{
         '{1'b1,  2, 1'b0, 1'b0, "rise_early"},
         '{1'b1,  1, 1'b0, 1'b1, "rise_qual"},
         '{1'b1,  6, 1'b0, 1'b1, "rise_cnt"},
         '{1'b1,  1, 1'b1, 1'b0, "rise_out"},
         '{1'b1, 10, 1'b1, 1'b0, "high_hold"},
         '{1'b0,  2, 1'b1, 1'b0, "fall_early"},
         '{1'b0,  1, 1'b1, 1'b1, "fall_qual"},
         '{1'b0,  7, 1'b0, 1'b0, "fall_out"},
         '{1'b0,  5, 1'b0, 1'b0, "low_hold"},
         '{1'b1,  5, 1'b0, 1'b1, "bounce_hi"},
         '{1'b0,  3, 1'b0, 1'b0, "bounce_lo"},
         '{1'b1,  9, 1'b0, 1'b1, "final_cnt"},
         '{1'b1,  1, 1'b1, 1'b0, "final_out"}
      };
      rst_a  = 1'b1;
      rst_b  = 1'b1;
      ifa.in = 1'b0;
      ifb.in = 1'b1;
      push(2, 1'b0, 1'b0, 1'b0, "a_reset");
      push(2, 1'b1, 1'b1, 1'b0, "b_reset");
      repeat (2) step();
      rst_a = 1'b0;
      rst_b = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         push(1, 1'b0, 1'b0, 1'b0, "a_idle");
         step();
      end
      for (int i = 0; i < 13; i++) begin
         ifa.in = tbl[i].in_v;
         push(tbl[i].hold, 1'b0, tbl[i].o, tbl[i].q, tbl[i].nm);
         repeat (tbl[i].hold) step();
      end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      chk("glitch_after_bounce", ifa.glitch_cnt, 8'd1);
`endif
      ifa.in = 1'b0;
      push(12, 1'b0, 1'b0, 1'b0, "back_low");
      repeat (12) step();
      ifa.in = 1'b1;
      push(7, 1'b0, 1'b0, 1'b1, "pre_rst_cnt5");
      repeat (7) step();
      rst_a = 1'b1;
      push(1, 1'b0, 1'b0, 1'b0, "rst_mid");
      step();
      rst_a = 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
      chk("glitch_rst", ifa.glitch_cnt, 8'd0);
`endif
      push(9,  1'b0, 1'b0, 1'b1, "post_rst_cnt");
      push(10, 1'b0, 1'b1, 1'b0, "post_rst_out");
      repeat (10) step();
`ifdef DEBOUNCE_GLITCH_CNT_EN
      for (int n = 1; n <= 300; n++) begin
         ifa.in = 1'b0;
         repeat (2) step();
         ifa.in = 1'b1;
         repeat (3) step();
         if (n == 200) chk("glitch_200", ifa.glitch_cnt, 8'd200);
      end
      push(5, 1'b0, 1'b1, 1'b0, "sat_out");
      repeat (5) step();
      chk("glitch_sat", ifa.glitch_cnt, 8'd255);
`endif
      ifb.in = 1'b0;
      push(2, 1'b1, 1'b1, 1'b0, "b_fall_early");
      push(3, 1'b1, 1'b0, 1'b0, "b_fall_out");
      repeat (3) step();
      ifb.in = 1'b1;
      push(2, 1'b1, 1'b0, 1'b0, "b_rise_early");
      push(3, 1'b1, 1'b1, 1'b0, "b_rise_out");
      repeat (6) step();
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
